clock_divider_multi: RTL and testbench

- Parametrised, multi-channel successor to the fixed three-output clock generator.
- Derives NCH divided clock-enable waveforms from the single system clock clk_in; the default build runs at 50 MHz.
- Each channel has its own run-time divisor. Divisor changes apply glitch-free at period boundaries through a shadow register.
- Each channel also produces a one-cycle tick pulse per period.
- Outputs are registered and intended for use as enables/strobes, not as new clock domains.

---
 rtl/clock_divider_multi.sv | 90 +++++++++
 tb/tb_clock_divider_multi.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
`timescale 1ns/1ps
// clock_divider_multi: NCH independent clock-enable dividers with shadowed run-time divisors.
// Optional feature: define PHASE_ALIGN_EN to add an align input that restarts every enabled channel.
module clock_divider_multi #(
    parameter int NCH = 3,
    parameter int CNT_W = 16,
    parameter int CH_W = 2,
    parameter logic [NCH*CNT_W-1:0] DIV_INIT = {16'd1316, 16'd1000, 16'd5000}
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
`ifdef PHASE_ALIGN_EN
    input  logic             align,
`endif
    input  logic             load,
    input  logic [CH_W-1:0]  load_ch,
    input  logic [CNT_W-1:0] load_div,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    logic load_valid;

    assign load_valid = load && (int'(load_ch) < NCH);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_next;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_shd;
        logic [CNT_W-1:0] low_len;
        logic             run;
        logic             wrap;
        logic             restart;
        logic             wr_sel;
        logic             clk_r;
        logic             tick_r;
        logic             pend_r;

        // A divisor of 0 or 1 parks the channel, exactly like a cleared enable.
        assign run      = en[c] && (div_act >= CNT_W'(2));
        assign wrap     = run && (cnt >= div_act - CNT_W'(1));
        assign cnt_next = wrap ? '0 : cnt + CNT_W'(1);
        assign low_len  = div_act - (div_act >> 1);
        assign wr_sel   = load_valid && (load_ch == CH_W'(c));

`ifdef PHASE_ALIGN_EN
        assign restart = !run || (align && en[c]);
`else
        assign restart = !run;
`endif

        // Shadow commits only at a period boundary; a same-edge write lands after the commit.
        always_ff @(posedge clk_in) begin
            if (rst) begin
                cnt     <= '0;
                div_act <= DIV_INIT[c*CNT_W +: CNT_W];
                div_shd <= DIV_INIT[c*CNT_W +: CNT_W];
                pend_r  <= 1'b0;
                clk_r   <= 1'b0;
                tick_r  <= 1'b0;
            end else begin
                if (restart) begin
                    cnt    <= '0;
                    clk_r  <= 1'b0;
                    tick_r <= 1'b0;
                end else begin
                    cnt    <= cnt_next;
                    clk_r  <= (cnt_next >= low_len);
                    tick_r <= wrap;
                end
                if ((restart || wrap) && pend_r) begin
                    div_act <= div_shd;
                    pend_r  <= 1'b0;
                end
                if (wr_sel) begin
                    div_shd <= load_div;
                    pend_r  <= 1'b1;
                end
            end
        end

        assign clk_out[c] = clk_r;
        assign tick[c]    = tick_r;
        assign pending[c] = pend_r;
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
`timescale 1ns/1ps
// Self-checking bench for clock_divider_multi: vector table, directed corner sequences, and a
// randomized run checked every cycle against a timestamp-based reference model.
module tb_clock_divider_multi;

    localparam int NCH = 3;
    localparam int CNT_W = 16;
    localparam int CH_W = 2;
    localparam int INIT_DIV [NCH] = '{5000, 1000, 1316};

    logic             clk_in = 1'b0;
    logic             rst;
    logic [NCH-1:0]   en;
    logic             load;
    logic [CH_W-1:0]  load_ch;
    logic [CNT_W-1:0] load_div;
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   pending;
`ifdef PHASE_ALIGN_EN
    logic             align;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: each channel remembers the edge number its current period started on.
    int cyc = 0;
    int m_act [NCH];
    int m_shd [NCH];
    int m_start [NCH];
    bit m_pend [NCH];
    logic [NCH-1:0] exp_clk = '0;
    logic [NCH-1:0] exp_tick = '0;
    logic [NCH-1:0] exp_pend = '0;

    typedef struct {
        logic           rst_v;
        logic [2:0]     en_v;
        logic           load_v;
        logic [1:0]     ch_v;
        logic [15:0]    div_v;
        logic [2:0]     exp_c;
        logic [2:0]     exp_t;
        logic [2:0]     exp_p;
    } vec_t;

    vec_t vecs [19];

    clock_divider_multi dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .en       (en),
`ifdef PHASE_ALIGN_EN
        .align    (align),
`endif
        .load     (load),
        .load_ch  (load_ch),
        .load_div (load_div),
        .clk_out  (clk_out),
        .tick     (tick),
        .pending  (pending)
    );

    always #10 clk_in = ~clk_in;

    task automatic modelStep();
        cyc++;
        for (int c = 0; c < NCH; c++) begin
            int pos;
            bit running;
            bit restart;
            bit boundary;
            pos = cyc - m_start[c];
            if (rst) begin
                m_act[c]   = INIT_DIV[c];
                m_shd[c]   = INIT_DIV[c];
                m_pend[c]  = 1'b0;
                m_start[c] = cyc;
                exp_clk[c] = 1'b0;
                exp_tick[c] = 1'b0;
            end else begin
                running = en[c] && (m_act[c] >= 2);
                restart = !running;
`ifdef PHASE_ALIGN_EN
                if (align && en[c]) restart = 1'b1;
`endif
                boundary = 1'b0;
                exp_clk[c] = 1'b0;
                exp_tick[c] = 1'b0;
                if (restart) begin
                    m_start[c] = cyc;
                    boundary = 1'b1;
                end else if (pos == m_act[c]) begin
                    m_start[c] = cyc;
                    exp_tick[c] = 1'b1;
                    boundary = 1'b1;
                end else begin
                    exp_clk[c] = (pos >= m_act[c] - m_act[c] / 2);
                end
                if (boundary && m_pend[c]) begin
                    m_act[c] = m_shd[c];
                    m_pend[c] = 1'b0;
                end
                if (load && int'(load_ch) == c) begin
                    m_shd[c] = int'(load_div);
                    m_pend[c] = 1'b1;
                end
            end
            exp_pend[c] = m_pend[c];
        end
    endtask

    task automatic checkOutput(input string name, input logic [NCH-1:0] ec,
                               input logic [NCH-1:0] et, input logic [NCH-1:0] ep);
        tests_run++;
        if ({clk_out, tick, pending} !== {ec, et, ep}) begin
            tests_failed++;
            $display("[TB] FAIL %s cyc=%0d: got clk_out=%b tick=%b pending=%b, want clk_out=%b tick=%b pending=%b",
                     name, cyc, clk_out, tick, pending, ec, et, ep);
        end
    endtask

    task automatic checkInt(input string name, input int got, input int want);
        tests_run++;
        if (got != want) begin
            tests_failed++;
            $display("[TB] FAIL %s cyc=%0d: got %0d, want %0d", name, cyc, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        modelStep();
        @(negedge clk_in);
        checkOutput("model", exp_clk, exp_tick, exp_pend);
    endtask

    task automatic applyStimulus(input logic r, input logic [NCH-1:0] e, input logic ld,
                                 input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] dv);
        rst = r;
        en = e;
        load = ld;
        load_ch = ch;
        load_div = dv;
        step();
        rst = 1'b0;
        load = 1'b0;
    endtask

    task automatic cyclesToTick(input int c, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!tick[c] && n <= limit);
    endtask

    task automatic cyclesToRise(input int c, input int limit, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!clk_out[c] && n <= limit);
    endtask

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int k;
        int rise [NCH];
        int nt [NCH];
        int highs;

        rst = 1'b1;
        en = '0;
        load = 1'b0;
        load_ch = '0;
        load_div = '0;
`ifdef PHASE_ALIGN_EN
        align = 1'b0;
`endif

        // Small-divisor walk: stopped/disabled commits, bad channel, reset over a pending write.
        vecs[0]  = '{1'b1, 3'b000, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};
        vecs[1]  = '{1'b0, 3'b000, 1'b1, 2'd1, 16'd4, 3'b000, 3'b000, 3'b010};
        vecs[2]  = '{1'b0, 3'b000, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};
        vecs[3]  = '{1'b0, 3'b010, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};
        vecs[4]  = '{1'b0, 3'b010, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b000};
        vecs[5]  = '{1'b0, 3'b010, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b000};
        vecs[6]  = '{1'b0, 3'b010, 1'b0, 2'd0, 16'd0, 3'b000, 3'b010, 3'b000};
        vecs[7]  = '{1'b0, 3'b010, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};
        vecs[8]  = '{1'b0, 3'b010, 1'b1, 2'd3, 16'd9, 3'b010, 3'b000, 3'b000};
        vecs[9]  = '{1'b0, 3'b010, 1'b1, 2'd0, 16'd1, 3'b010, 3'b000, 3'b001};
        vecs[10] = '{1'b0, 3'b010, 1'b0, 2'd0, 16'd0, 3'b000, 3'b010, 3'b000};
        vecs[11] = '{1'b0, 3'b011, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000};
        vecs[12] = '{1'b0, 3'b011, 1'b1, 2'd0, 16'd3, 3'b010, 3'b000, 3'b001};
        vecs[13] = '{1'b0, 3'b011, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b000};
        vecs[14] = '{1'b0, 3'b011, 1'b0, 2'd0, 16'd0, 3'b000, 3'b010, 3'b000};
        vecs[15] = '{1'b0, 3'b011, 1'b0, 2'd0, 16'd0, 3'b001, 3'b000, 3'b000};
        vecs[16] = '{1'b0, 3'b011, 1'b0, 2'd0, 16'd0, 3'b010, 3'b001, 3'b000};
        vecs[17] = '{1'b0, 3'b011, 1'b1, 2'd1, 16'd7, 3'b010, 3'b000, 3'b010};
        vecs[18] = '{1'b1, 3'b011, 1'b1, 2'd2, 16'd5, 3'b000, 3'b000, 3'b000};

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].rst_v, vecs[i].en_v, vecs[i].load_v, vecs[i].ch_v, vecs[i].div_v);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_c, vecs[i].exp_t, vecs[i].exp_p);
        end

        // Default divisors free-running from reset.
        applyStimulus(1'b1, 3'b000, 1'b0, 2'd0, 16'd0);
        en = 3'b111;
        for (int c = 0; c < NCH; c++) begin
            rise[c] = -1;
            nt[c] = 0;
        end
        for (int j = 1; j <= 12000; j++) begin
            step();
            for (int c = 0; c < NCH; c++) begin
                if (clk_out[c] && rise[c] < 0) rise[c] = j;
                if (tick[c]) nt[c]++;
            end
        end
        checkInt("ch0_first_rise", rise[0], 2500);
        checkInt("ch1_first_rise", rise[1], 500);
        checkInt("ch2_first_rise", rise[2], 658);
        checkInt("ch0_ticks", nt[0], 2);
        checkInt("ch1_ticks", nt[1], 12);
        checkInt("ch2_ticks", nt[2], 9);

        // Disable ch0 in its high phase, try a bad-channel load, then re-enable.
        cyclesToRise(0, 6000, n);
        checkInt("ch0_rise_wait", n, 500);
        en = 3'b110;
        step();
        checkInt("ch0_off_next_edge", int'(clk_out[0]), 0);
        applyStimulus(1'b0, 3'b110, 1'b1, 2'd3, 16'd2);
        checkInt("bad_ch_no_pending", int'(pending), 0);
        for (int j = 0; j < 8; j++) step();
        en = 3'b111;
        cyclesToRise(0, 3000, n);
        checkInt("ch0_reenable_rise", n, 2500);

        // ch1 retargeted to 4 during its high phase.
        cyclesToRise(1, 1100, n);
        for (int j = 0; j < 100; j++) step();
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd1, 16'd4);
        checkInt("ch1_pending_set", int'(pending[1]), 1);
        n = 0;
        while (pending[1] && n <= 1000) begin
            step();
            n++;
        end
        checkInt("ch1_commit_in_time", int'(n <= 1000), 1);
        k = 0;
        for (int j = 0; j < 40; j++) begin
            step();
            if (tick[1]) k++;
        end
        checkInt("ch1_ticks_period4", k, 10);

        // ch0: write 5, then write 7 on the wrap edge that commits the 5.
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd0, 16'd5);
        k = 0;
        while ((cyc + 1 - m_start[0]) != m_act[0] && k < 6000) begin
            step();
            k++;
        end
        checkInt("ch0_wrap_found", int'(k < 6000), 1);
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd0, 16'd7);
        checkInt("ch0_wrap_tick", int'(tick[0]), 1);
        checkInt("ch0_pending_kept", int'(pending[0]), 1);
        cyclesToTick(0, 20, n);
        checkInt("ch0_period5", n, 5);
        checkInt("ch0_pending_cleared", int'(pending[0]), 0);
        cyclesToTick(0, 20, n);
        checkInt("ch0_period7", n, 7);

        // ch2 parked with divisor 1, then restarted with 3.
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd2, 16'd1);
        cyclesToTick(2, 1400, n);
        checkInt("ch2_commit_in_time", int'(n <= 1316), 1);
        checkInt("ch2_pending_cleared", int'(pending[2]), 0);
        k = 0;
        highs = 0;
        for (int j = 0; j < 100; j++) begin
            step();
            if (tick[2]) k++;
            if (clk_out[2]) highs++;
        end
        checkInt("ch2_stopped_ticks", k, 0);
        checkInt("ch2_stopped_highs", highs, 0);
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd2, 16'd3);
        checkInt("ch2_pending_set", int'(pending[2]), 1);
        step();
        checkInt("ch2_commit_next_edge", int'(pending[2]), 0);
        cyclesToTick(2, 10, n);
        checkInt("ch2_period3_a", n, 3);
        cyclesToTick(2, 10, n);
        checkInt("ch2_period3_b", n, 3);

        // Reset with a write pending restores the power-up divisors.
        applyStimulus(1'b0, 3'b111, 1'b1, 2'd1, 16'd9);
        applyStimulus(1'b1, 3'b111, 1'b0, 2'd0, 16'd0);
        checkOutput("reset_mid_run", 3'b000, 3'b000, 3'b000);
        cyclesToRise(0, 3000, n);
        checkInt("ch0_rise_after_reset", n, 2500);

`ifdef PHASE_ALIGN_EN
        for (int j = 0; j < 777; j++) step();
        align = 1'b1;
        step();
        align = 1'b0;
        rise[0] = -1;
        rise[1] = -1;
        for (int j = 1; j <= 2600; j++) begin
            step();
            if (clk_out[0] && rise[0] < 0) rise[0] = j;
            if (clk_out[1] && rise[1] < 0) rise[1] = j;
        end
        checkInt("align_ch0_rise", rise[0], 2500);
        checkInt("align_ch1_rise", rise[1], 500);
`endif

        // Randomized traffic with small divisors against the model.
        applyStimulus(1'b1, 3'b111, 1'b0, 2'd0, 16'd0);
        for (int j = 0; j < 4000; j++) begin
            if ($urandom_range(0, 15) == 0) en = 3'($urandom);
            load = ($urandom_range(0, 3) == 0);
            load_ch = 2'($urandom_range(0, 3));
            load_div = 16'($urandom_range(0, 9));
            rst = ($urandom_range(0, 499) == 0);
`ifdef PHASE_ALIGN_EN
            align = ($urandom_range(0, 99) == 0);
`endif
            step();
        end
        rst = 1'b0;
        load = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
